nbit_comp_pipe: RTL and testbench

Pipelined, parametrised magnitude comparator with valid/ready streaming handshake and selectable signed/unsigned mode. Each accepted operand pair produces one mutually exclusive gt/lt/eq result two cycles later. Saturating per-outcome event counters support monitoring and statistics. It is the successor to the combinational N-bit comparator and sits between a sample source and downstream decision logic.

---
 rtl/comp_pkg.sv | 40 ++++
 rtl/nbit_comp_pipe_sat_counter.sv | 38 +++
 rtl/nbit_comp_pipe.sv | 124 ++++++++++++
 tb/tb_nbit_comp_pipe.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
// comp_pkg: shared types and the reference compare function for nbit_comp_pipe.
//   cmp_res_t  one-hot {gt, lt, eq} result
//   RES_*      the legal result codes, RES_NONE for "no result present"
//   cmp_f      compares two zero-extended operands of width w, signed or unsigned
package comp_pkg;

    // Widest operand cmp_f can handle; callers zero-extend to this width.
    localparam int MAX_W = 64;

    typedef logic [2:0] cmp_res_t;

    localparam cmp_res_t RES_GT   = 3'b100;
    localparam cmp_res_t RES_LT   = 3'b010;
    localparam cmp_res_t RES_EQ   = 3'b001;
    localparam cmp_res_t RES_NONE = 3'b000;

    // Two's-complement order equals unsigned order once the sign bit is
    // inverted, so signed mode only flips bit w-1 of both operands.
    function automatic cmp_res_t cmp_f(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic             signed_mode,
        input int unsigned      w
    );
        logic [MAX_W-1:0] msb;
        logic [MAX_W-1:0] ka;
        logic [MAX_W-1:0] kb;
        msb = {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
        ka  = signed_mode ? (a ^ msb) : a;
        kb  = signed_mode ? (b ^ msb) : b;
        if (ka > kb) begin
            cmp_f = RES_GT;
        end else if (ka < kb) begin
            cmp_f = RES_LT;
        end else begin
            cmp_f = RES_EQ;
        end
    endfunction

endpackage

// File: rtl/nbit_comp_pipe_sat_counter.sv
// sat_counter: saturating event counter.
//   clk, rst_n  clock, asynchronous active-low reset
//   inc         count one event this cycle
//   clr         synchronous clear; wins over inc
//   count       current value, sticks at 2^CNT_W-1
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/nbit_comp_pipe.sv
// nbit_comp_pipe: two-stage pipelined magnitude comparator with streaming
// handshake and saturating per-outcome counters.
//   in_valid/in_ready/a/b/signed_mode  operand pair input stream
//   out_valid/out_ready/gt/lt/eq       one-hot result output stream
//   gt_cnt/lt_cnt/eq_cnt               counts of transferred results
//   clr                                synchronous clear of the counters
//
// Handshake: a beat transfers on a rising edge where valid & ready are both 1.
// The producer holds valid and its data until the transfer; ready may depend
// combinationally on the downstream ready (in_ready follows out_ready).
module nbit_comp_pipe
    import comp_pkg::*;
#(
    parameter int N     = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    input  logic             clr
);

    logic         s1_valid_q, s1_valid_d;
    logic [N-1:0] s1_a_q,     s1_a_d;
    logic [N-1:0] s1_b_q,     s1_b_d;
    logic         s1_mode_q,  s1_mode_d;
    logic         out_valid_q, out_valid_d;
    cmp_res_t     res_q,      res_d;

    logic s2_en;
    logic s1_en;
    logic in_xfer;
    logic out_xfer;

    always_comb begin
        s2_en    = !out_valid_q || out_ready;
        s1_en    = !s1_valid_q || s2_en;
        in_xfer  = in_valid && s1_en;
        out_xfer = out_valid_q && out_ready;

        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_mode_d  = s1_mode_q;
        if (s1_en) begin
            s1_valid_d = in_xfer;
        end
        if (in_xfer) begin
            s1_a_d    = a;
            s1_b_d    = b;
            s1_mode_d = signed_mode;
        end

        out_valid_d = out_valid_q;
        res_d       = res_q;
        if (s2_en) begin
            out_valid_d = s1_valid_q;
            // Flags are forced low with no result so idle outputs read 0.
            res_d = s1_valid_q ? cmp_f(MAX_W'(s1_a_q), MAX_W'(s1_b_q), s1_mode_q, N)
                               : RES_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_mode_q   <= 1'b0;
            out_valid_q <= 1'b0;
            res_q       <= RES_NONE;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_mode_q   <= s1_mode_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
        end
    end

    assign in_ready  = s1_en;
    assign out_valid = out_valid_q;
    assign gt        = res_q[2];
    assign lt        = res_q[1];
    assign eq        = res_q[0];

    sat_counter #(.CNT_W(CNT_W)) u_gt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_xfer && res_q[2]),
        .clr   (clr),
        .count (gt_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_lt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_xfer && res_q[1]),
        .clr   (clr),
        .count (lt_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_eq_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_xfer && res_q[0]),
        .clr   (clr),
        .count (eq_cnt)
    );

endmodule

// File: tb/tb_nbit_comp_pipe.sv
// Bench for nbit_comp_pipe (N=16, CNT_W=2 so saturation is reachable).
module tb_nbit_comp_pipe;

    localparam int NW      = 16;
    localparam int CW      = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam logic [2:0] E_GT = 3'b100;
    localparam logic [2:0] E_LT = 3'b010;
    localparam logic [2:0] E_EQ = 3'b001;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          signed_mode = 1'b0;
    logic          out_ready = 1'b0;
    logic          clr = 1'b0;
    logic [NW-1:0] a = '0;
    logic [NW-1:0] b = '0;
    logic          in_ready;
    logic          out_valid;
    logic          gt, lt, eq;
    logic [CW-1:0] gt_cnt, lt_cnt, eq_cnt;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    nbit_comp_pipe #(.N(NW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .gt          (gt),
        .lt          (lt),
        .eq          (eq),
        .gt_cnt      (gt_cnt),
        .lt_cnt      (lt_cnt),
        .eq_cnt      (eq_cnt),
        .clr         (clr)
    );

    // ---------------- scoreboard state ----------------
    int         checks = 0;
    int         failures = 0;
    logic [2:0] exp_q[$];
    int         cyc_q[$];
    int         m_gt = 0, m_lt = 0, m_eq = 0;
    int         pops = 0;
    logic       lat_chk = 1'b0;
    logic       prev_stall = 1'b0;
    logic [2:0] prev_res = 3'b000;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: interpret operands as integers and compare.
    function automatic logic [2:0] ref_cmp(input logic [NW-1:0] x, input logic [NW-1:0] y,
                                           input logic m);
        longint vx, vy;
        vx = longint'(x);
        vy = longint'(y);
        if (m) begin
            if (vx >= (64'sd1 << (NW - 1))) vx = vx - (64'sd1 << NW);
            if (vy >= (64'sd1 << (NW - 1))) vy = vy - (64'sd1 << NW);
        end
        if (vx > vy) return E_GT;
        if (vx < vy) return E_LT;
        return E_EQ;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    // ---------------- driver + per-cycle checker ----------------
    task automatic step(input logic iv, input logic [NW-1:0] ia, input logic [NW-1:0] ib,
                        input logic im, input logic [2:0] iexp, input logic ordy,
                        input logic iclr, output logic acc);
        logic [2:0] res;
        @(posedge clk);
        #1;
        in_valid    = iv;
        a           = ia;
        b           = ib;
        signed_mode = im;
        out_ready   = ordy;
        clr         = iclr;
        @(negedge clk);
        res = {gt, lt, eq};
        if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_flags", res, prev_res);
        end
        if (out_valid) begin
            check("onehot", $countones(res), 1);
            if (exp_q.size() == 0) begin
                check("spurious_out", exp_q.size(), 1);
            end else begin
                check("result", res, exp_q[0]);
                if (lat_chk) check("latency", cyc - cyc_q[0], 2);
            end
        end else begin
            check("idle_flags", res, 0);
        end
        check("in_ready", in_ready, !(exp_q.size() == 2 && !ordy));
        check("gt_cnt", gt_cnt, m_gt);
        check("lt_cnt", lt_cnt, m_lt);
        check("eq_cnt", eq_cnt, m_eq);

        prev_stall = out_valid && !ordy;
        prev_res   = res;
        if (out_valid && ordy && exp_q.size() > 0) begin
            case (exp_q[0])
                E_GT:    m_gt = sat_inc(m_gt);
                E_LT:    m_lt = sat_inc(m_lt);
                default: m_eq = sat_inc(m_eq);
            endcase
            void'(exp_q.pop_front());
            void'(cyc_q.pop_front());
            pops++;
        end
        if (iclr) begin
            m_gt = 0;
            m_lt = 0;
            m_eq = 0;
        end
        acc = iv && in_ready;
        if (acc) begin
            exp_q.push_back(iexp);
            cyc_q.push_back(cyc);
        end
    endtask

    task automatic idle(input logic iclr);
        logic acc;
        step(1'b0, '0, '0, 1'b0, 3'b000, 1'b1, iclr, acc);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) idle(1'b0);
        idle(1'b0);
        check("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [NW-1:0] a;
        logic [NW-1:0] b;
        logic          m;
        logic [2:0]    exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic acc;
        int   k;
        int   pops0;
        int   n_acc;
        logic [NW-1:0] ra, rb;
        logic rm;
        logic [NW-1:0] bp_a[4];
        logic [NW-1:0] bp_b[4];

        vecs[0] = '{16'h0005, 16'h0003, 1'b0, E_GT};
        vecs[1] = '{16'h0003, 16'h0005, 1'b0, E_LT};
        vecs[2] = '{16'h1234, 16'h1234, 1'b0, E_EQ};
        vecs[3] = '{16'hFFFF, 16'h0001, 1'b1, E_LT};
        vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, E_GT};
        vecs[5] = '{16'h8000, 16'h7FFF, 1'b1, E_LT};
        vecs[6] = '{16'h0000, 16'hFFFF, 1'b0, E_LT};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_flags", {gt, lt, eq}, 0);
        check("rst_gt_cnt", gt_cnt, 0);
        check("rst_lt_cnt", lt_cnt, 0);
        check("rst_eq_cnt", eq_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // Unsigned basic, back to back, latency 2
        lat_chk = 1'b1;
        for (int i = 0; i < 3; i++)
            step(1'b1, vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].exp, 1'b1, 1'b0, acc);
        drain();
        check("basic_gt_cnt", gt_cnt, 1);
        check("basic_lt_cnt", lt_cnt, 1);
        check("basic_eq_cnt", eq_cnt, 1);
        idle(1'b1);

        // Signed vs unsigned and extremes
        for (int i = 3; i < 7; i++)
            step(1'b1, vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].exp, 1'b1, 1'b0, acc);
        drain();

        // Backpressure: 5 stalled cycles, only two pairs fit
        lat_chk = 1'b0;
        bp_a[0] = 16'h0010; bp_b[0] = 16'h0001;
        bp_a[1] = 16'h0001; bp_b[1] = 16'h0010;
        bp_a[2] = 16'h4444; bp_b[2] = 16'h4444;
        bp_a[3] = 16'h8001; bp_b[3] = 16'h0002;
        pops0 = pops;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, bp_a[k], bp_b[k], 1'b1, ref_cmp(bp_a[k], bp_b[k], 1'b1), 1'b0, 1'b0, acc);
            if (acc) k++;
        end
        check("bp_accepted", k, 2);
        for (int i = 0; i < 20 && k < 4; i++) begin
            step(1'b1, bp_a[k], bp_b[k], 1'b1, ref_cmp(bp_a[k], bp_b[k], 1'b1), 1'b1, 1'b0, acc);
            if (acc) k++;
        end
        drain();
        check("bp_results", pops - pops0, 4);

        // Saturation at CNT_W=2, then clr against a gt transfer
        idle(1'b1);
        lat_chk = 1'b1;
        for (int i = 0; i < 5; i++)
            step(1'b1, 16'h00A0 + 16'(i), 16'h00A0 + 16'(i), 1'b0, E_EQ, 1'b1, 1'b0, acc);
        drain();
        check("sat_eq_cnt", eq_cnt, 3);
        check("sat_gt_cnt", gt_cnt, 0);
        check("sat_lt_cnt", lt_cnt, 0);
        step(1'b1, 16'h0009, 16'h0002, 1'b0, E_GT, 1'b1, 1'b0, acc);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        check("clr_gt_cnt", gt_cnt, 0);
        check("clr_eq_cnt", eq_cnt, 0);
        check("clr_pipe_empty", exp_q.size(), 0);

        // Random regression
        lat_chk = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 40000 && n_acc < 10000; i++) begin
            ra = NW'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = ra;
                1:       rb = ra ^ 16'h8000;
                2:       rb = 16'h8000;
                default: rb = NW'($urandom);
            endcase
            rm = 1'($urandom_range(0, 1));
            step($urandom_range(0, 3) != 0, ra, rb, rm, ref_cmp(ra, rb, rm),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, acc);
            if (acc) n_acc++;
        end
        check("rand_accepted", n_acc >= 10000, 1);
        drain();

        // Asynchronous reset with two pairs in flight
        step(1'b1, 16'h0100, 16'h0200, 1'b0, E_LT, 1'b1, 1'b0, acc);
        step(1'b1, 16'h0300, 16'h0200, 1'b0, E_GT, 1'b1, 1'b0, acc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #1;
        check("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_flags", {gt, lt, eq}, 0);
        check("mid_rst_gt_cnt", gt_cnt, 0);
        check("mid_rst_lt_cnt", lt_cnt, 0);
        check("mid_rst_eq_cnt", eq_cnt, 0);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        cyc_q.delete();
        m_gt = 0;
        m_lt = 0;
        m_eq = 0;
        prev_stall = 1'b0;
        repeat (4) idle(1'b0);
        lat_chk = 1'b1;
        step(1'b1, 16'hFFFE, 16'h0003, 1'b1, E_LT, 1'b1, 1'b0, acc);
        drain();
        check("post_rst_lt_cnt", lt_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
